// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared widths, buffer entry and FSM types for the fetch stage
package riscv_fetch_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam int INST_BYTES = 4;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
   typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry shift buffer of fetched {pc, instruction} pairs
module fetch_fifo
   import riscv_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output fetch_entry_t head,
   output logic         empty,
   output logic         full
);
   fetch_entry_t tail;
   assign empty = count == 2'd0;
   assign full = count == 2'd2;
   // head always holds the oldest entry; a pop shifts tail forward
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 2'd0;
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         if (push && (empty || (count == 2'd1 && pop))) head <= din;
         else if (pop) head <= tail;
         if (push && (full || (count == 2'd1 && !pop))) tail <= din;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, run/halt FSM and redirect handling feeding a
// two-entry fetch buffer toward decode
module instruction_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter logic [XLEN-1:0] PC_LIMIT = 64'd88,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] inst_address,
   input  logic [ILEN-1:0] instruction,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instruction,
   output logic            halted
);
   fetch_state_t state;
   fetch_entry_t head;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] target;
   logic [1:0] count;
   logic empty;
   logic full;
   logic pop;
   logic fetch;
   if (FIFO_DEPTH != 2) begin : g_depth_check
      $error("instruction_fetch_unit: FIFO_DEPTH must be 2");
   end
   assign pc_seq = pc + XLEN'(INST_BYTES);
   assign target = {redirect_pc[XLEN-1:2], 2'b00};
   assign out_valid = count != 2'd0;
   assign pop = out_valid & out_ready & ~redirect_valid;
   assign fetch = (state == RUN) & ~redirect_valid & (~full | pop);
   assign inst_address = pc;
   assign halted = state == HALT;
   assign out_pc = empty ? '0 : head.pc;
   assign out_instruction = empty ? '0 : head.instr;
   fetch_fifo u_fifo (
      .clk(clk),
      .reset(reset),
      .push(fetch),
      .pop(pop),
      .flush(redirect_valid),
      .din('{pc: pc, instr: instruction}),
      .count(count),
      .head(head),
      .empty(empty),
      .full(full)
   );
   // redirect outranks fetch; halting happens on the fetch that reaches the limit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
         state <= RUN;
      end else if (redirect_valid) begin
         pc <= target;
         state <= target < PC_LIMIT ? RUN : HALT;
      end else if (fetch) begin
         pc <= pc_seq;
         if (pc_seq >= PC_LIMIT) state <= HALT;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for the fetch stage
module tb_instruction_fetch_unit;
   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [63:0] inst_address;
   logic [31:0] instruction;
   logic redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instruction;
   logic halted;
   int total = 0;
   int bad = 0;
   int cyc;
   exp_t exp_q[$];
   exp_t e;
   logic [31:0] rom [22] = '{
      32'h00000913, 32'h00a00993, 32'h04b40863, 32'h00000a13, 32'h41390ab3, 32'hfffa8a93,
      32'h00000b13, 32'h00090e93, 32'h02be8663, 32'h003e9e13, 32'h01c50e33, 32'h00093d03,
      32'h008e3d83, 32'h01bd5663, 32'h01be3023, 32'h00ae3423, 32'h001b0b13, 32'h001e8e93,
      32'hfd5ff06f, 32'h00190913, 32'hfa9ff06f, 32'hfa000ae3};

   always #5 clk = ~clk;

   always_comb instruction = inst_address < 64'd88 ? rom[int'(inst_address[6:2])] : 32'h00000013;

   instruction_fetch_unit dut (
      .clk(clk),
      .reset(reset),
      .inst_address(inst_address),
      .instruction(instruction),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc(out_pc),
      .out_instruction(out_instruction),
      .halted(halted)
   );

   // monitor: a handshake seen at the falling edge completes on the next rising edge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready && !redirect_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_delivery: got pc=%h ins=%h want nothing", out_pc, out_instruction);
         end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_instruction !== e.ins) begin
               bad++;
               $display("FAIL delivery: got pc=%h ins=%h want pc=%h ins=%h", out_pc, out_instruction, e.pc, e.ins);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [63:0] pc, input logic [31:0] ins);
      exp_q.push_back('{pc: pc, ins: ins});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset = 1'b1;
      redirect_valid = 1'b0;
      out_ready = rdy;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain(input int limit, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < limit) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic redirect(input logic [63:0] target);
      redirect_valid = 1'b1;
      redirect_pc = target;
      out_ready = 1'b1;
      step(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      #2;
      chk("reset_inst_address", inst_address, 64'h0);
      chk("reset_out_valid", 64'(out_valid), 64'h0);
      chk("reset_out_pc", out_pc, 64'h0);
      chk("reset_halted", 64'(halted), 64'h0);
      do_reset(1'b1);
      expect_word(64'h0, 32'h00000913);
      expect_word(64'h4, 32'h00a00993);
      expect_word(64'h8, 32'h04b40863);
      drain(10, cyc);
      chk("startup_cycles", 64'(cyc), 64'd4);

      do_reset(1'b0);
      step(5);
      chk("bp_count", 64'(dut.u_fifo.count), 64'd2);
      chk("bp_inst_address", inst_address, 64'h8);
      chk("bp_head_pc", out_pc, 64'h0);
      out_ready = 1'b1;
      expect_word(64'h0, 32'h00000913);
      expect_word(64'h4, 32'h00a00993);
      expect_word(64'h8, 32'h04b40863);
      drain(10, cyc);
      chk("bp_no_gap_cycles", 64'(cyc), 64'd3);

      do_reset(1'b0);
      step(5);
      chk("full_before_redirect", 64'(dut.u_fifo.count), 64'd2);
      redirect(64'h20);
      chk("redirect_bubble", 64'(out_valid), 64'h0);
      chk("redirect_inst_address", inst_address, 64'h20);
      expect_word(64'h20, 32'h02be8663);
      drain(5, cyc);
      chk("redirect_cycles", 64'(cyc), 64'd2);

      do_reset(1'b1);
      for (int i = 0; i < 21; i++) expect_word(64'(i * 4), rom[i]);
      expect_word(64'h54, 32'hfa000ae3);
      drain(40, cyc);
      chk("freerun_cycles", 64'(cyc), 64'd23);
      step(2);
      chk("halt_flag", 64'(halted), 64'h1);
      chk("halt_inst_address", inst_address, 64'd88);
      chk("halt_drained", 64'(out_valid), 64'h0);
      step(3);
      chk("halt_holds", 64'(halted), 64'h1);
      chk("halt_pc_holds", inst_address, 64'd88);
      expect_word(64'h8, 32'h04b40863);
      redirect(64'h8);
      chk("unhalt_flag", 64'(halted), 64'h0);
      chk("unhalt_inst_address", inst_address, 64'h8);
      drain(5, cyc);

      expect_word(64'h2c, 32'h00093d03);
      redirect(64'h2e);
      chk("misaligned_inst_address", inst_address, 64'h2c);
      drain(5, cyc);

      do_reset(1'b0);
      step(2);
      redirect(64'h54);
      out_ready = 1'b0;
      step(1);
      chk("pre_reset_halted", 64'(halted), 64'h1);
      chk("pre_reset_valid", 64'(out_valid), 64'h1);
      chk("pre_reset_out_pc", out_pc, 64'h54);
      chk("pre_reset_out_ins", 64'(out_instruction), 64'hfa000ae3);
      chk("pre_reset_inst_address", inst_address, 64'd88);
      #2;
      reset = 1'b1;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'h0);
      chk("async_out_pc", out_pc, 64'h0);
      chk("async_out_ins", 64'(out_instruction), 64'h0);
      chk("async_halted", 64'(halted), 64'h0);
      chk("async_inst_address", inst_address, 64'h0);
      step(1);
      reset = 1'b0;
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Program-counter and fetch stage sitting directly upstream of the instruction memory. It drives the byte address to the instruction memory and captures the 32-bit word returned in the same cycle, because the memory read is combinational. Each fetched word is buffered with its PC in a 2-entry queue, which feeds decode through a valid/ready handshake. It accepts taken-branch redirects from execute and halts fetch at the end of the program image.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
PC_LIMIT, 64'd88, first byte address past the program image; fetch stops when PC >= PC_LIMIT.
FIFO_DEPTH, 2, fetch buffer entries; fixed at 2, any other value is a compile-time error.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
inst_address  output  64  byte address to the instruction memory; equals the PC register
instruction  input  32  word from the instruction memory for inst_address, valid in the same cycle
redirect_valid  input  1  taken branch/jump from execute, single-cycle pulse
redirect_pc  input  64  target address for the redirect
out_valid  output  1  buffer head is valid
out_ready  input  1  decode accepts the head
out_pc  output  64  PC of the head entry
out_instruction  output  32  instruction of the head entry
halted  output  1  fetch stopped at PC_LIMIT

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or mid-handshake):
  - pc = RESET_PC, count = 0, state = RUN.
  - out_valid = 0, out_pc = 0, out_instruction = 0, halted = 0.
  - inst_address = RESET_PC.
- When the buffer is empty, out_pc and out_instruction are driven to 0. When it is non-empty, they reflect the head entry.
- The FSM has two states, RUN and HALT. halted = (state == HALT).
- pop = out_valid & out_ready & ~redirect_valid.
- fetch = (state == RUN) & ~redirect_valid & (count < 2 | pop).
- Per edge, in priority order:
  1. redirect_valid:
     - flush the buffer (count <= 0); any concurrent handshake is discarded.
     - pc <= {redirect_pc[63:2], 2'b00}; the low bits are silently cleared.
     - state <= RUN if the aligned target < PC_LIMIT, else HALT.
  2. fetch:
     - push {pc, instruction}; pop the head in the same edge if pop.
     - pc <= pc + 4, with 64-bit wrap-around (no overflow flag).
     - If pc + 4 >= PC_LIMIT, state <= HALT.
  3. Otherwise:
     - pop if pop; pc holds.
- Push and pop in the same edge with count == 2 is legal; count stays 2.
- Push with count == 2 and no pop cannot occur, because fetch is gated.
- HALT:
  - pc holds at its last value (>= PC_LIMIT); no pushes occur.
  - The buffer continues to drain to decode.
  - Only redirect or reset leaves HALT.
- Latency:
  - Word at pc is visible on out_* one edge after fetch.
  - After a redirect at edge N, out_valid = 0 in cycle N+1 and the target word is valid after edge N+1.
- Throughput: 1 instruction/cycle with out_ready held high.
- inst_address is purely the PC register; there is no combinational path from redirect_pc.

Decomposition:
- Package riscv_fetch_pkg:
  - XLEN = 64, ILEN = 32, INST_BYTES = 4.
  - typedef fetch_entry_t = struct {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;}.
  - typedef fetch_state_t = enum {RUN, HALT}.
- Sub-module fetch_fifo:
  - 2-entry FIFO of fetch_entry_t with push/pop/flush.
  - Outputs count, head, empty, full.
  - Same asynchronous active-high reset.
- The top level holds the PC, the FSM and the fetch/redirect logic.

Test Plan:
- Reset release with out_ready = 1 and the bubble-sort image loaded:
  - inst_address = 0.
  - After edge 1: out_pc = 0, out_instruction = 32'h00000913.
  - After edge 3: out_pc = 8, out_instruction = 32'h04b40863.
- Backpressure, out_ready = 0 from reset for 5 cycles:
  - count = 2, holding PC 0 and 4.
  - inst_address held at 8.
  - Raise out_ready: 0, 4, 8 are delivered on consecutive cycles with no gap.
- Redirect, redirect_valid pulse with redirect_pc = 64'h20 while the buffer is full:
  - Next cycle out_valid = 0.
  - Following cycle out_pc = 0x20, out_instruction = 32'h02be8663.
- Halt at PC_LIMIT = 88, free-run:
  - Last word pushed is pc = 0x54, 32'hfa000ae3.
  - halted = 1 and inst_address = 88 thereafter; the buffer drains.
  - Redirect to 0x08 clears halted and delivers 32'h04b40863.
- Misaligned redirect, redirect_pc = 64'h2E:
  - out_pc = 0x2C, out_instruction = 32'h00093d03.
- Reset asserted mid-stream with out_valid = 1:
  - out_valid, out_pc and halted go to 0 immediately (asynchronous).
  - inst_address = RESET_PC before the next clock edge.
